// File: rtl/stdcore_spram_fifo.sv
// Valid/ready FIFO controller for a single-port 1-cycle-latency SRAM, with a 3-entry prefetch buffer.
// Optional peak-occupancy register enabled by STDCORE_SPRAM_FIFO_WATERMARK_EN.
module stdcore_spram_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] count,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
`ifdef STDCORE_SPRAM_FIFO_WATERMARK_EN
  ,
  output logic [AW+1:0] max_count
`endif
);

  localparam int unsigned MW = AW + 1;
  localparam int unsigned CW = AW + 2;
  localparam int unsigned OB = 3;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] mem_cnt;
  logic          rd_inflight;
  logic [1:0]    ob_cnt;
  logic          rd_turn;
  logic [DW-1:0] ob [OB];

  logic          rd_want;
  logic          push;
  logic          pop;
  logic          rd_sel;
  logic [1:0]    cap_idx;

  // Arbitration uses registered state only, so out_ready never reaches the SRAM port.
  assign rd_want  = (mem_cnt != '0) && ((3'(ob_cnt) + 3'(rd_inflight)) < 3'd3);
  assign in_ready = !rst && (mem_cnt < MW'(DEPTH)) && !(rd_want && rd_turn);
  assign push     = in_valid && in_ready;
  assign rd_sel   = !rst && rd_want && !push;
  assign pop      = out_valid && out_ready;

  assign sram_ce_n  = !(push || rd_sel);
  assign sram_we_n  = !push;
  assign sram_addr  = push ? wr_ptr : rd_ptr;
  assign sram_wdata = in_data;

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = ob[0];
  assign count     = CW'(mem_cnt) + CW'(rd_inflight) + CW'(ob_cnt);
  assign cap_idx   = ob_cnt - {1'b0, pop};

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      ob_cnt      <= 2'd0;
      rd_turn     <= 1'b1;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_sel) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      mem_cnt     <= mem_cnt + MW'(push) - MW'(rd_sel);
      rd_inflight <= rd_sel;
      ob_cnt      <= ob_cnt + 2'(rd_inflight) - 2'(pop);
      if (rd_sel) rd_turn <= 1'b0;
      else if (push && rd_want) rd_turn <= 1'b1;
    end
  end

  // Prefetch buffer: head at entry 0; a lone head stays put when popped so out_data holds.
  always_ff @(posedge clk) begin
    if (pop && (ob_cnt > 2'd1)) begin
      ob[0] <= ob[1];
      ob[1] <= ob[2];
    end
    for (int i = 0; i < OB; i++) begin
      if (!rst && rd_inflight && (cap_idx == 2'(i))) ob[i] <= sram_rdata;
    end
  end

`ifdef STDCORE_SPRAM_FIFO_WATERMARK_EN
  logic [CW-1:0] count_nxt;

  // Reads and captures only move entries between stages; occupancy changes on push/pop.
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) max_count <= '0;
    else if (count_nxt > max_count) max_count <= count_nxt;
  end
`endif

endmodule
